// File: rtl/io_port_pkg.sv
// Shared definitions for the memory-mapped IO port: register select codes,
// reset values, input port width and the filter counter sizing helper.
package io_port_pkg;

  localparam int PORT_IN_W = 8;

  // Byte offsets inside the 16-byte register window
  localparam logic [3:0] OFS_PORT_OUT    = 4'h0;
  localparam logic [3:0] OFS_PORT_IN     = 4'h4;
  localparam logic [3:0] OFS_EDGE_STATUS = 4'h8;
  localparam logic [3:0] OFS_EDGE_MASK   = 4'hC;

  // Word select decoded from Address[3:2]
  typedef enum logic [1:0] {
    REG_PORT_OUT    = OFS_PORT_OUT[3:2],
    REG_PORT_IN     = OFS_PORT_IN[3:2],
    REG_EDGE_STATUS = OFS_EDGE_STATUS[3:2],
    REG_EDGE_MASK   = OFS_EDGE_MASK[3:2]
  } reg_sel_e;

  localparam logic [31:0]          PORT_OUT_RST    = 32'h0;
  localparam logic [PORT_IN_W-1:0] EDGE_STATUS_RST = '0;
  localparam logic [PORT_IN_W-1:0] EDGE_MASK_RST   = '0;

  // Bits needed for a stability counter that must be able to hold 0..cycles
  function automatic int filter_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/io_input_filter.sv
// One PortIn bit: two-flop synchronizer followed by a stability filter.
// The filtered level only changes once the synchronized input has differed
// from it for FILTER_CYCLES consecutive cycles; o_rise flags the cycle whose
// rising edge will move the filtered level from 0 to 1.
module io_input_filter
  import io_port_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise
);

  localparam int            CW       = filter_cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_accept;

  assign w_diff   = r_sync2 ^ r_level;
  // The counter is accepted before it could pass FILTER_CYCLES, so it never wraps
  assign w_accept = w_diff && (r_cnt >= CNT_LAST);
  assign o_level  = r_level;
  assign o_rise   = w_accept && r_sync2;

  // Synchronize the pin and qualify level changes by consecutive-cycle count
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_port_controller.sv
// Memory-mapped IO port for a single-cycle processor: a 32-bit output
// register, an 8-bit filtered input port and rising-edge capture with W1C
// status. Define IO_PORT_IRQ_EN to add the edge mask register and the
// registered interrupt output; otherwise offset 0xC reads 0 and Irq is 0.
module io_port_controller
  import io_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h1001_0000,
  parameter int          FILTER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [31:0]          Address,
  input  logic [31:0]          WriteData,
  output logic [31:0]          ReadData,
  input  logic [PORT_IN_W-1:0] PortIn,
  output logic [31:0]          PortOut,
  output logic                 Irq
);

  logic [31:0]          r_port_out;
  logic [PORT_IN_W-1:0] r_edge_status;

  logic                 w_hit;
  reg_sel_e             w_sel;
  logic                 w_rd;
  logic                 w_wr;
  logic [PORT_IN_W-1:0] w_port_in;
  logic [PORT_IN_W-1:0] w_rise;
  logic [PORT_IN_W-1:0] w_clr;
  logic [PORT_IN_W-1:0] w_status_next;
  logic [PORT_IN_W-1:0] w_edge_mask;
  logic                 w_unused;

  // Byte lane bits are irrelevant: every register is a full word
  assign w_unused = &{1'b0, Address[1:0]};

  assign w_hit = (Address[31:4] == BASE_ADDR[31:4]);
  assign w_sel = reg_sel_e'(Address[3:2]);
  // Bus accesses are dead while reset is held low
  assign w_rd  = MemRead && w_hit && reset;
  assign w_wr  = MemWrite && w_hit && reset;

  assign PortOut = r_port_out;

  genvar gi;
  generate
    for (gi = 0; gi < PORT_IN_W; gi++) begin : g_filt
      io_input_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
      ) u_filt (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (PortIn[gi]),
        .o_level(w_port_in[gi]),
        .o_rise (w_rise[gi])
      );
    end
  endgenerate

  // A new edge on the same bit as a W1C clear must survive, so set is ORed last
  assign w_clr         = (w_wr && (w_sel == REG_EDGE_STATUS)) ? WriteData[PORT_IN_W-1:0] : '0;
  assign w_status_next = (r_edge_status & ~w_clr) | w_rise;

  // Output register and edge status update
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_port_out    <= PORT_OUT_RST;
      r_edge_status <= EDGE_STATUS_RST;
    end else begin
      if (w_wr && (w_sel == REG_PORT_OUT)) begin
        r_port_out <= WriteData;
      end
      r_edge_status <= w_status_next;
    end
  end

`ifdef IO_PORT_IRQ_EN
  logic [PORT_IN_W-1:0] r_edge_mask;
  logic                 r_irq;

  // Edge mask register and interrupt registered from masked status
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_edge_mask <= EDGE_MASK_RST;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr && (w_sel == REG_EDGE_MASK)) begin
        r_edge_mask <= WriteData[PORT_IN_W-1:0];
      end
      r_irq <= |(r_edge_status & r_edge_mask);
    end
  end

  assign w_edge_mask = r_edge_mask;
  assign Irq         = r_irq;
`else
  assign w_edge_mask = '0;
  assign Irq         = 1'b0;
`endif

  // Zero-wait-state read mux from registered state; pre-write value on read+write
  always_comb begin
    ReadData = 32'h0;
    if (w_rd) begin
      case (w_sel)
        REG_PORT_OUT:    ReadData = r_port_out;
        REG_PORT_IN:     ReadData = {{(32-PORT_IN_W){1'b0}}, w_port_in};
        REG_EDGE_STATUS: ReadData = {{(32-PORT_IN_W){1'b0}}, r_edge_status};
        REG_EDGE_MASK:   ReadData = {{(32-PORT_IN_W){1'b0}}, w_edge_mask};
        default:         ReadData = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller: a table of single-cycle bus vectors
// for the register map, then hand-timed sequences for filter latency, glitch
// rejection, W1C/set collision, interrupt timing and mid-filter reset.
// Interrupt expectations follow IO_PORT_IRQ_EN when it is defined.
module tb_io_port_controller;

  localparam logic [31:0] BASE = 32'h1001_0000;

`ifdef IO_PORT_IRQ_EN
  localparam logic [31:0] MASK_RB = 32'h0000_00FF;
  localparam logic        IRQ_ON  = 1'b1;
`else
  localparam logic [31:0] MASK_RB = 32'h0;
  localparam logic        IRQ_ON  = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        Irq;

  int n_checks = 0;
  int n_fail   = 0;

  io_port_controller #(
    .BASE_ADDR    (BASE),
    .FILTER_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Address  (Address),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .PortIn   (PortIn),
    .PortOut  (PortOut),
    .Irq      (Irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_out;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  // Combinational read inside the current half-cycle window
  task automatic rd_now(input logic [31:0] addr, input logic [31:0] exp, input string name);
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    Address  = addr;
    #1;
    check(name, ReadData, exp);
  endtask

  // Single-cycle write taking effect on the next rising edge
  task automatic wr_cycle(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    MemRead   = 1'b0;
    MemWrite  = 1'b1;
    Address   = addr;
    WriteData = data;
    @(negedge clk);
    MemWrite  = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, BASE,           32'h0,         32'h0,         32'h0,         "idle_after_reset"};
    vecs[1]  = '{1'b0, 1'b1, BASE,           32'hDEAD_BEEF, 32'h0,         32'h0,         "wr_port_out"};
    vecs[2]  = '{1'b1, 1'b0, BASE,           32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, "rd_port_out"};
    vecs[3]  = '{1'b1, 1'b0, BASE + 32'h10,  32'h0,         32'h0,         32'hDEAD_BEEF, "rd_outside_window"};
    vecs[4]  = '{1'b1, 1'b0, BASE + 32'h4,   32'h0,         32'h0,         32'hDEAD_BEEF, "rd_port_in_idle"};
    vecs[5]  = '{1'b1, 1'b1, BASE + 32'h3,   32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rdwr_prewrite_value"};
    vecs[6]  = '{1'b1, 1'b0, BASE,           32'h0,         32'h1234_5678, 32'h1234_5678, "rd_after_rdwr"};
    vecs[7]  = '{1'b0, 1'b1, BASE + 32'h4,   32'hFF,        32'h0,         32'h1234_5678, "wr_port_in_ignored"};
    vecs[8]  = '{1'b1, 1'b0, BASE + 32'h4,   32'h0,         32'h0,         32'h1234_5678, "rd_port_in_unchanged"};
    vecs[9]  = '{1'b0, 1'b1, BASE + 32'h8,   32'hFFFF_FFFF, 32'h0,         32'h1234_5678, "w1c_empty_status"};
    vecs[10] = '{1'b1, 1'b0, BASE + 32'h8,   32'h0,         32'h0,         32'h1234_5678, "rd_status_zero"};
    vecs[11] = '{1'b0, 1'b1, BASE + 32'hC,   32'hFFFF_FFFF, 32'h0,         32'h1234_5678, "wr_edge_mask"};
    vecs[12] = '{1'b1, 1'b0, BASE + 32'hC,   32'h0,         MASK_RB,       32'h1234_5678, "rd_edge_mask"};
    vecs[13] = '{1'b0, 1'b1, 32'h1002_0000,  32'h0,         32'h0,         32'h1234_5678, "wr_other_base"};
    vecs[14] = '{1'b1, 1'b0, BASE,           32'h0,         32'h1234_5678, 32'h1234_5678, "rd_after_miss_wr"};
    vecs[15] = '{1'b1, 1'b0, 32'h1002_0000,  32'h0,         32'h0,         32'h1234_5678, "rd_other_base"};

    reset     = 1'b0;
    MemRead   = 1'b1;
    MemWrite  = 1'b0;
    Address   = BASE;
    WriteData = 32'h0;
    PortIn    = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("rdata_during_reset", ReadData, 32'h0);
    check("irq_reset", {31'h0, Irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Register map vectors, one bus cycle each
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      MemRead   = vecs[i].rd;
      MemWrite  = vecs[i].wr;
      Address   = vecs[i].addr;
      WriteData = vecs[i].wdata;
      #1;
      check({vecs[i].name, "_rdata"}, ReadData, vecs[i].exp_rdata);
      check({vecs[i].name, "_portout"}, PortOut, vecs[i].exp_out);
    end

    // Reset with a write pending: write ignored, read returns 0, state cleared
    @(negedge clk);
    reset     = 1'b0;
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    Address   = BASE;
    WriteData = 32'hAAAA_5555;
    #1;
    check("rdata_in_reset_cycle", ReadData, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rd_now(BASE, 32'h0, "port_out_after_reset");
    check("portout_after_reset", PortOut, 32'h0);
    rd_now(BASE + 32'hC, 32'h0, "mask_after_reset");

    // 8'h00 -> 8'h5A: visible on the 6th sampling edge
    @(negedge clk);
    PortIn   = 8'h5A;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    Address  = BASE + 32'h4;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("port_in_edge%0d", k), ReadData, (k < 6) ? 32'h0 : 32'h5A);
    end
    rd_now(BASE + 32'h8, 32'h5A, "status_5a");
    check("irq_masked_off", {31'h0, Irq}, 32'h0);

    wr_cycle(BASE + 32'h8, 32'hFF);
    rd_now(BASE + 32'h8, 32'h0, "status_cleared");
    PortIn = 8'h00;
    repeat (8) @(negedge clk);
    rd_now(BASE + 32'h4, 32'h0, "port_in_fell");
    rd_now(BASE + 32'h8, 32'h0, "no_status_on_fall");

    // 3-cycle glitch on bit0 is rejected
    @(negedge clk);
    MemRead = 1'b0;
    PortIn  = 8'h01;
    repeat (3) @(negedge clk);
    PortIn = 8'h00;
    repeat (8) @(negedge clk);
    rd_now(BASE + 32'h4, 32'h0, "glitch3_port_in");
    rd_now(BASE + 32'h8, 32'h0, "glitch3_status");

    // 4-cycle pulse is exactly long enough to register
    @(negedge clk);
    MemRead = 1'b0;
    PortIn  = 8'h01;
    repeat (4) @(negedge clk);
    PortIn = 8'h00;
    repeat (8) @(negedge clk);
    rd_now(BASE + 32'h8, 32'h1, "pulse4_status");
    rd_now(BASE + 32'h4, 32'h0, "pulse4_port_in_back");
    wr_cycle(BASE + 32'h8, 32'hFF);

    // Build status 8'h03, then collide a W1C of bit0 with a new bit0 edge
    @(negedge clk);
    PortIn = 8'h03;
    repeat (7) @(negedge clk);
    rd_now(BASE + 32'h8, 32'h03, "status_03");
    PortIn = 8'h02;
    repeat (7) @(negedge clk);
    rd_now(BASE + 32'h4, 32'h02, "bit0_low");
    rd_now(BASE + 32'h8, 32'h03, "status_03_kept");
    PortIn = 8'h03;
    repeat (5) @(negedge clk);
    MemRead   = 1'b0;
    MemWrite  = 1'b1;
    Address   = BASE + 32'h8;
    WriteData = 32'h01;
    @(negedge clk);
    rd_now(BASE + 32'h8, 32'h03, "set_wins_over_clear");
    rd_now(BASE + 32'h4, 32'h03, "bit0_edge_landed");
    wr_cycle(BASE + 32'h8, 32'h01);
    rd_now(BASE + 32'h8, 32'h02, "w1c_bit0_no_edge");

    // Interrupt: mask bit2, edge on bit2, then clear
    wr_cycle(BASE + 32'h8, 32'hFF);
    wr_cycle(BASE + 32'hC, 32'h04);
    @(negedge clk);
    MemRead = 1'b0;
    PortIn  = 8'h07;
    repeat (5) @(negedge clk);
    #1;
    check("irq_before_edge", {31'h0, Irq}, 32'h0);
    @(negedge clk);
    #1;
    check("irq_on_status_edge", {31'h0, Irq}, 32'h0);
    rd_now(BASE + 32'h8, 32'h04, "status_bit2");
    @(negedge clk);
    #1;
    check("irq_one_after", {31'h0, Irq}, {31'h0, IRQ_ON});
    MemRead   = 1'b0;
    MemWrite  = 1'b1;
    Address   = BASE + 32'h8;
    WriteData = 32'h04;
    @(negedge clk);
    MemWrite = 1'b0;
    #1;
    check("irq_at_clear_edge", {31'h0, Irq}, {31'h0, IRQ_ON});
    @(negedge clk);
    #1;
    check("irq_cleared", {31'h0, Irq}, 32'h0);

    // Reset mid-filter: registers clear and the filter restarts a full count
    wr_cycle(BASE, 32'h1);
    check("portout_one", PortOut, 32'h1);
    PortIn = 8'h0F;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rd_now(BASE,          32'h0, "rst_port_out");
    rd_now(BASE + 32'h4,  32'h0, "rst_port_in");
    rd_now(BASE + 32'h8,  32'h0, "rst_status");
    rd_now(BASE + 32'hC,  32'h0, "rst_mask");
    check("rst_portout_pin", PortOut, 32'h0);
    check("rst_irq", {31'h0, Irq}, 32'h0);
    Address = BASE + 32'h4;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("restart_edge%0d", k), ReadData, (k < 6) ? 32'h0 : 32'h0F);
    end
    rd_now(BASE + 32'h8, 32'h0F, "restart_status");

    @(negedge clk);
    MemRead = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
